// File: rtl/riscv_load_store_unit.sv
// Load/store unit: computes the effective address, checks alignment and runs one
// req/ack word access with sign/zero-extended load return and an ack timeout.
module riscv_load_store_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] imm,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] rs2_q, rs2_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;

    logic [31:0] ea_start;
    logic        legal;
    logic        misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Decode of the incoming request, used only when start is accepted in idle.
    always_comb begin
        ea_start = rs1 + imm;
        if (is_store) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        misaligned = ((funct3[1:0] == 2'b01) && ea_start[0]) ||
                     ((funct3[1:0] == 2'b10) && (ea_start[1:0] != 2'b00));
    end

    always_comb begin
        st_wdata = rs2_q;
        st_wmask = 4'b1111;
        unique case (funct3_q[1:0])
            2'b00: begin
                st_wdata = {4{rs2_q[7:0]}};
                st_wmask = 4'b0001 << ea_q[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_q[15:0]}};
                st_wmask = ea_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = rs2_q;
                st_wmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        unique case (ea_q[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = ea_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h000000, ld_byte};
            3'b101:  ld_ext = {16'h0000, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ea_d        = ea_q;
        rs2_d       = rs2_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        wait_d      = wait_q;
        err_d       = err_q;
        load_data_d = load_data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ea_d       = ea_start;
                    rs2_d      = rs2;
                    funct3_d   = funct3;
                    is_store_d = is_store;
                    wait_d     = 8'd0;
                    if (!legal || misaligned) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                // Ack in the timeout cycle still counts as normal completion.
                if (mem_ack) begin
                    if (!is_store_q) begin
                        load_data_d = ld_ext;
                    end
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (wait_q == WaitLast) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ea_q        <= 32'h0;
            rs2_q       <= 32'h0;
            funct3_q    <= 3'b000;
            is_store_q  <= 1'b0;
            wait_q      <= 8'd0;
            err_q       <= 1'b0;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            ea_q        <= ea_d;
            rs2_q       <= rs2_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StResp);
        err       = done && err_q;
        load_data = load_data_q;
        mem_req   = (state_q == StAccess);
        mem_we    = mem_req && is_store_q;
        mem_addr  = mem_req ? {ea_q[31:2], 2'b00} : 32'h0;
        mem_wdata = mem_we ? st_wdata : 32'h0;
        mem_wmask = mem_we ? st_wmask : 4'b0000;
    end

endmodule
